// File: rtl/icache_pkg.sv
// icache_pkg: FSM encodings, address field widths and fetch-address layout for the instruction cache.
package icache_pkg;
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MEM_READ = 2'd1;
  localparam logic [1:0] ST_UPDATE   = 2'd2;
  localparam int TAG_W   = 3;
  localparam int IDX_W   = 3;
  localparam int OFF_W   = 2;
  localparam int BLOCK_W = 128;
  typedef logic [1:0] state_t;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
  } addr_t;
endpackage

// File: rtl/icache_word_sel.sv
// icache_word_sel: picks one 32-bit word out of a 128-bit cache line by word offset.
module icache_word_sel
  import icache_pkg::*;
(
  input  logic [BLOCK_W-1:0] line,
  input  logic [OFF_W-1:0]   offset,
  output logic [31:0]        word
);
  always_comb word = line[{offset, 5'd0} +: 32];
endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped read-only instruction cache; zero-latency hits, stall-and-refill on miss.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int NUM_BLOCKS      = 8,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int ADDR_W          = 10
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [ADDR_W-1:0]             ADDRESS,
  output logic [31:0]                   INSTRUCTION,
  output logic                          BUSYWAIT,
  output logic                          MEM_READ,
  output logic [TAG_W+IDX_W-1:0]        MEM_ADDRESS,
  input  logic [WORDS_PER_BLOCK*32-1:0] MEM_READDATA,
  input  logic                          MEM_BUSYWAIT
);
  addr_t fa;
  state_t state, next;
  logic [NUM_BLOCKS-1:0] valid;
  logic [TAG_W-1:0] tags [NUM_BLOCKS];
  logic [WORDS_PER_BLOCK*32-1:0] data [NUM_BLOCKS];
  logic [31:0] word, last;
  logic hit, unused_lo;
  assign fa = addr_t'(ADDRESS[ADDR_W-1:2]);
  assign unused_lo = ^ADDRESS[1:0];
  assign hit = valid[fa.idx] && tags[fa.idx] == fa.tag;
  icache_word_sel u_sel (
    .line  (data[fa.idx]),
    .offset(fa.off),
    .word  (word)
  );
  // On a miss the output keeps showing the last word served, not stale array data.
  assign INSTRUCTION = hit ? word : last;
  assign BUSYWAIT    = RESET && (state != ST_IDLE || !hit);
  assign MEM_READ    = state == ST_MEM_READ;
  assign MEM_ADDRESS = {fa.tag, fa.idx};
  always_comb
    next = state == ST_IDLE     ? (hit ? ST_IDLE : ST_MEM_READ) :
           state == ST_MEM_READ ? (MEM_BUSYWAIT ? ST_MEM_READ : ST_UPDATE) :
                                  ST_IDLE;
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state <= ST_IDLE;
      valid <= '0;
      last  <= '0;
    end else begin
      state <= next;
      if (state == ST_UPDATE) valid[fa.idx] <= 1'b1;
      if (hit) last <= word;
    end
  // State is forced to IDLE asynchronously, so an abandoned refill never writes.
  always_ff @(posedge CLK)
    if (state == ST_UPDATE) begin
      data[fa.idx] <= MEM_READDATA;
      tags[fa.idx] <= fa.tag;
    end
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed vector bench for icache_ctrl with a cycle-stepped instruction memory model.
module tb_icache_ctrl;
  logic CLK = 1'b0;
  logic RESET;
  logic [9:0] ADDRESS;
  logic [31:0] INSTRUCTION;
  logic BUSYWAIT, MEM_READ, MEM_BUSYWAIT;
  logic [5:0] MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  int checks = 0;
  int fails = 0;
  logic [31:0] prev_instr;

  typedef struct {
    string        nm;
    logic [9:0]   addr;
    int           lat;
    logic [127:0] blk;
    logic [31:0]  exp;
    bit           miss;
    logic [5:0]   madr;
  } vec_t;
  vec_t vecs[$];

  localparam logic [127:0] COLD = 128'h0000000C_00000008_00000004_00000000;
  localparam logic [127:0] JUNK = {4{32'hBAD0BAD0}};

  always #5 CLK = ~CLK;

  icache_ctrl dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .ADDRESS     (ADDRESS),
    .INSTRUCTION (INSTRUCTION),
    .BUSYWAIT    (BUSYWAIT),
    .MEM_READ    (MEM_READ),
    .MEM_ADDRESS (MEM_ADDRESS),
    .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [9:0] a, input int lat, input logic [127:0] blk,
                     input logic [31:0] exp, input bit miss, input logic [5:0] madr);
    vec_t v;
    v.nm = nm; v.addr = a; v.lat = lat; v.blk = blk; v.exp = exp; v.miss = miss; v.madr = madr;
    vecs.push_back(v);
  endtask

  // Called just after a rising edge; returns just after the edge on which the CPU advances.
  task automatic run(input vec_t v);
    int stall = 0;
    int reads = 0;
    logic [5:0] seen = '0;
    ADDRESS = v.addr;
    MEM_READDATA = v.blk;
    MEM_BUSYWAIT = 1'b0;
    @(negedge CLK);
    check({v.nm, " busywait"}, {31'd0, BUSYWAIT}, {31'd0, v.miss});
    if (v.miss) begin
      check({v.nm, " hold"}, INSTRUCTION, prev_instr);
      @(posedge CLK);
      for (int k = 0; k < 40; k++) begin
        @(negedge CLK);
        if (!BUSYWAIT) break;
        stall++;
        if (MEM_READ) begin
          reads++;
          seen = MEM_ADDRESS;
        end
        MEM_BUSYWAIT = MEM_READ && reads <= v.lat;
      end
      check({v.nm, " stall"}, stall, v.lat + 2);
      check({v.nm, " reads"}, reads, v.lat + 1);
      check({v.nm, " mem_addr"}, {26'd0, seen}, {26'd0, v.madr});
    end else
      check({v.nm, " no_read"}, {31'd0, MEM_READ}, 32'd0);
    check({v.nm, " instr"}, INSTRUCTION, v.exp);
    prev_instr = v.exp;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    add("cold_miss",     10'h000, 5, COLD, 32'h00000000, 1, 6'd0);
    add("hit_004",       10'h004, 0, JUNK, 32'h00000004, 0, 6'd0);
    add("hit_008",       10'h008, 0, JUNK, 32'h00000008, 0, 6'd0);
    add("hit_00c",       10'h00C, 0, JUNK, 32'h0000000C, 0, 6'd0);
    add("idx1_miss",     10'h010, 2, 128'h44444444_33333333_22222222_11111111, 32'h11111111, 1, 6'd1);
    add("line0_hit",     10'h000, 0, JUNK, 32'h00000000, 0, 6'd0);
    add("conflict_miss", 10'h080, 3, 128'hCAFEF00D_33330080_22220080_DEADBEEF, 32'hDEADBEEF, 1, 6'd8);
    add("unaligned_hit", 10'h08E, 0, JUNK, 32'hCAFEF00D, 0, 6'd0);
    add("refetch_zlat",  10'h005, 0, COLD, 32'h00000004, 1, 6'd0);
    add("line1_hit",     10'h014, 0, JUNK, 32'h22222222, 0, 6'd0);
    add("top_line",      10'h3FF, 1, 128'h76543210_89ABCDEF_01234567_FEDCBA98, 32'h76543210, 1, 6'd63);
    add("post_reset",    10'h004, 1, COLD, 32'h00000004, 1, 6'd0);
    add("abandoned_idx", 10'h020, 2, 128'h0_0_0_5555AAAA, 32'h5555AAAA, 1, 6'd2);

    RESET = 1'b0;
    ADDRESS = '0;
    MEM_BUSYWAIT = 1'b0;
    MEM_READDATA = '0;
    prev_instr = '0;
    #12;
    check("reset busywait", {31'd0, BUSYWAIT}, 32'd0);
    check("reset mem_read", {31'd0, MEM_READ}, 32'd0);
    check("reset instr", INSTRUCTION, 32'd0);
    @(posedge CLK);
    #1 RESET = 1'b1;
    for (int i = 0; i < 11; i++) run(vecs[i]);

    // Reset in the third MEM_READ cycle of a refill.
    ADDRESS = 10'h020;
    MEM_BUSYWAIT = 1'b1;
    MEM_READDATA = {4{32'hFFFF0000}};
    repeat (3) @(posedge CLK);
    #1;
    check("mid_refill mem_read", {31'd0, MEM_READ}, 32'd1);
    RESET = 1'b0;
    #1;
    check("abort mem_read", {31'd0, MEM_READ}, 32'd0);
    check("abort busywait", {31'd0, BUSYWAIT}, 32'd0);
    check("abort instr", INSTRUCTION, 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    MEM_BUSYWAIT = 1'b0;
    prev_instr = '0;
    for (int i = 11; i < 13; i++) run(vecs[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Direct-mapped instruction cache. Answers the CPU's instruction fetch: the CPU drives PC and consumes INSTRUCTION.
- Sits between the CPU fetch port and the slow instruction memory. Serves hits with zero added latency.
- On a miss it stalls the CPU with BUSYWAIT, refills one 128-bit block from instruction memory, then serves the word.

Parameters:
- NUM_BLOCKS, 8, number of cache lines (power of 2).
- WORDS_PER_BLOCK, 4, number of 32-bit words per line (fixed 4; the memory port is 128 bits).
- ADDR_W, 10, number of byte-address bits used from PC; higher PC bits are ignored.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset (0 = reset).
- ADDRESS  in  ADDR_W  byte address of the fetch (PC[9:0]). Bits [1:0] are ignored.
- INSTRUCTION  out  32  fetched word; valid when BUSYWAIT=0.
- BUSYWAIT  out  1  stall request to the CPU PC register; PC must hold while this is 1.
- MEM_READ  out  1  refill request to instruction memory.
- MEM_ADDRESS  out  6  block address = ADDRESS[9:4].
- MEM_READDATA  in  128  refill block. Word 0 is in [31:0], word 3 is in [127:96].
- MEM_BUSYWAIT  in  1  memory busy; data is valid in the cycle this falls to 0 while MEM_READ=1.

Behaviour:
- Address split:
  - offset = ADDRESS[3:2]
  - index = ADDRESS[6:4]
  - tag = ADDRESS[9:7]
- Storage per line: valid bit, 3-bit tag, 128-bit data. No dirty bits; the cache is read-only.
- hit = valid[index] && tag_array[index] == tag. Evaluated combinationally.
- INSTRUCTION = data[index] word[offset] whenever hit; otherwise it holds its last value.

FSM states: IDLE, MEM_READ, UPDATE.
- IDLE:
  - BUSYWAIT = !hit.
  - MEM_READ = 0.
  - Goes to MEM_READ at the next edge if !hit.
- MEM_READ:
  - MEM_READ = 1, MEM_ADDRESS = {tag, index}, BUSYWAIT = 1.
  - Stays while MEM_BUSYWAIT = 1.
  - Goes to UPDATE at the first edge with MEM_BUSYWAIT = 0.
- UPDATE (exactly 1 cycle):
  - MEM_READ = 0, BUSYWAIT = 1.
  - At the edge: data[index] <= MEM_READDATA, tag_array[index] <= tag, valid[index] <= 1.
  - Then goes to IDLE.
- After UPDATE, in IDLE, the access hits. BUSYWAIT drops combinationally in that cycle and the CPU advances on the following edge.

Latency:
- Hit: 0 stall cycles.
- Miss: memory latency L cycles (MEM_BUSYWAIT high) + 1 (MEM_READ entry) + 1 (UPDATE) stall cycles.

Reset (RESET = 0, asynchronous):
- Every valid bit cleared; state = IDLE; MEM_READ = 0; INSTRUCTION = 32'h0.
- BUSYWAIT = 0 while RESET is asserted.
- After release, the first fetch misses.
- Reset during MEM_READ or UPDATE: the refill is abandoned, nothing is written, and MEM_READ is deasserted immediately.

Boundary conditions:
- ADDRESS changes while in MEM_READ: illegal because the CPU is stalled. The cache uses the live ADDRESS; the bench must check that the CPU holds it.
- Same index, different tag: the line is overwritten. No victim handling is needed.
- MEM_BUSYWAIT = 0 on the first MEM_READ cycle: the refill is legal; go to UPDATE next.
- Unaligned ADDRESS[1:0] ≠ 0: treated as aligned.

Decomposition:
- Shared package `icache_pkg`:
  - state encoding IDLE=2'd0, MEM_READ=2'd1, UPDATE=2'd2;
  - field widths TAG_W=3, IDX_W=3, OFF_W=2;
  - BLOCK_W=128.
- One sub-module, `icache_word_sel`: 4:1 32-bit word mux from the 128-bit line by offset. Reused by the future data cache.
- FSM and arrays stay in the top module.

Test Plan:
- Cold miss: RESET pulse, ADDRESS=0x000, memory returns 128'h0000000C_00000008_00000004_00000000 after 5 busy cycles.
  - MEM_READ=1 with MEM_ADDRESS=0.
  - BUSYWAIT high for 7 cycles.
  - Then INSTRUCTION=0x00000000.
- Hits in block: after the above, ADDRESS=0x004, 0x008, 0x00C.
  - BUSYWAIT=0 throughout.
  - INSTRUCTION=0x4, 0x8, 0xC.
  - MEM_READ never asserted.
- Conflict miss: ADDRESS=0x080 (same index 0, tag 1), memory block word0=0xDEADBEEF.
  - Miss refill; INSTRUCTION=0xDEADBEEF.
  - Re-fetching 0x000 misses again.
- Different index: ADDRESS=0x010 after the cold fill.
  - Miss with MEM_ADDRESS=1.
  - Line 0 still hits afterwards.
- Reset mid-refill: assert RESET=0 on the 3rd MEM_READ cycle.
  - MEM_READ=0 and BUSYWAIT=0 immediately.
  - After release, ADDRESS=0x000 misses (valid was cleared).
- Zero-latency memory: MEM_BUSYWAIT held 0.
  - Miss stalls exactly 2 cycles.
  - Correct word is returned.
